e_stage_reg: RTL and testbench

//  Decode->Execute pipeline register. Captures decoded instruction fields each cycle and

---
 rtl/e_stage_reg.sv | 155 +++++++++++++++
 tb/tb_e_stage_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/e_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : e_stage_reg
//  Purpose  : Decode->Execute pipeline register. Captures the decoded
//             instruction fields each cycle and presents them as E_* to the
//             execute stage. Detects load-use hazards against the
//             instruction sitting in decode, inserts bubbles, honours stall,
//             and keeps a saturating count of inserted bubbles.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1     clock, rising edge
//    rst_n          in   1     asynchronous reset, active low
//    d_op           in   OPW   decode-stage opcode
//    d_pc           in   DW    decode-stage PC
//    d_valA/B/C     in   DW    operand A, operand B, immediate
//    d_srcA/B       in   RW    source register indices of decode instruction
//    d_dstE/M       in   RW    ALU / memory destination indices (0 = none)
//    E_stall        in   1     hold E register contents
//    E_bubble       in   1     external bubble request (flush)
//    E_op           out  OPW   registered opcode
//    E_pc,E_valA/B/C out DW    registered values
//    E_dstE/M       out  RW    registered destinations
//    E_valid        out  1     1 = real instruction, 0 = bubble
//    ld_use_hazard  out  1     combinational; decode must stall F and D
//    bubble_cnt     out  CNTW  saturating count of bubbles inserted
// ============================================================================
module e_stage_reg #(
    parameter int              DW        = 32,
    parameter int              OPW       = 6,
    parameter int              RW        = 5,
    parameter logic [OPW-1:0]  BUBBLE_OP = 6'h3F,
    parameter logic [OPW-1:0]  LW_OP     = 6'h23,
    parameter int              CNTW      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  d_op,
    input  logic [DW-1:0]   d_pc,
    input  logic [DW-1:0]   d_valA,
    input  logic [DW-1:0]   d_valB,
    input  logic [DW-1:0]   d_valC,
    input  logic [RW-1:0]   d_srcA,
    input  logic [RW-1:0]   d_srcB,
    input  logic [RW-1:0]   d_dstE,
    input  logic [RW-1:0]   d_dstM,
    input  logic            E_stall,
    input  logic            E_bubble,
    output logic [OPW-1:0]  E_op,
    output logic [DW-1:0]   E_pc,
    output logic [DW-1:0]   E_valA,
    output logic [DW-1:0]   E_valB,
    output logic [DW-1:0]   E_valC,
    output logic [RW-1:0]   E_dstE,
    output logic [RW-1:0]   E_dstM,
    output logic            E_valid,
    output logic            ld_use_hazard,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [OPW-1:0]  e_op_q,    e_op_d;
    logic [DW-1:0]   e_pc_q,    e_pc_d;
    logic [DW-1:0]   e_vala_q,  e_vala_d;
    logic [DW-1:0]   e_valb_q,  e_valb_d;
    logic [DW-1:0]   e_valc_q,  e_valc_d;
    logic [RW-1:0]   e_dste_q,  e_dste_d;
    logic [RW-1:0]   e_dstm_q,  e_dstm_d;
    logic            e_valid_q, e_valid_d;
    logic [CNTW-1:0] cnt_q,     cnt_d;

    logic            hazard;
    logic            bub;

    // A valid load in E whose memory destination feeds either decode source.
    // Destination 0 means "no write", so register $0 can never match.
    assign hazard = (e_op_q == LW_OP) && e_valid_q && (e_dstm_q != '0) &&
                    ((e_dstm_q == d_srcA) || (e_dstm_q == d_srcB));

    assign bub = E_bubble | hazard;

    // Bubble has priority over stall: a flush must not be blocked by a hold.
    always_comb begin
        e_op_d    = e_op_q;
        e_pc_d    = e_pc_q;
        e_vala_d  = e_vala_q;
        e_valb_d  = e_valb_q;
        e_valc_d  = e_valc_q;
        e_dste_d  = e_dste_q;
        e_dstm_d  = e_dstm_q;
        e_valid_d = e_valid_q;
        cnt_d     = cnt_q;

        if (bub) begin
            e_op_d    = BUBBLE_OP;
            e_pc_d    = '0;
            e_vala_d  = '0;
            e_valb_d  = '0;
            e_valc_d  = '0;
            e_dste_d  = '0;
            e_dstm_d  = '0;
            e_valid_d = 1'b0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!E_stall) begin
            e_op_d    = d_op;
            e_pc_d    = d_pc;
            e_vala_d  = d_valA;
            e_valb_d  = d_valB;
            e_valc_d  = d_valC;
            e_dste_d  = d_dstE;
            e_dstm_d  = d_dstM;
            e_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_op_q    <= BUBBLE_OP;
            e_pc_q    <= '0;
            e_vala_q  <= '0;
            e_valb_q  <= '0;
            e_valc_q  <= '0;
            e_dste_q  <= '0;
            e_dstm_q  <= '0;
            e_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            e_op_q    <= e_op_d;
            e_pc_q    <= e_pc_d;
            e_vala_q  <= e_vala_d;
            e_valb_q  <= e_valb_d;
            e_valc_q  <= e_valc_d;
            e_dste_q  <= e_dste_d;
            e_dstm_q  <= e_dstm_d;
            e_valid_q <= e_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign E_op          = e_op_q;
    assign E_pc          = e_pc_q;
    assign E_valA        = e_vala_q;
    assign E_valB        = e_valb_q;
    assign E_valC        = e_valc_q;
    assign E_dstE        = e_dste_q;
    assign E_dstM        = e_dstm_q;
    assign E_valid       = e_valid_q;
    assign ld_use_hazard = hazard;
    assign bubble_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_e_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_stage_reg
//  Purpose  : Directed self-checking bench for e_stage_reg (counter width 4
//             so that saturation is reachable quickly).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_e_stage_reg;

    localparam int DW   = 32;
    localparam int OPW  = 6;
    localparam int RW   = 5;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [OPW-1:0]  d_op;
    logic [DW-1:0]   d_pc, d_valA, d_valB, d_valC;
    logic [RW-1:0]   d_srcA, d_srcB, d_dstE, d_dstM;
    logic            E_stall, E_bubble;
    logic [OPW-1:0]  E_op;
    logic [DW-1:0]   E_pc, E_valA, E_valB, E_valC;
    logic [RW-1:0]   E_dstE, E_dstM;
    logic            E_valid;
    logic            ld_use_hazard;
    logic [CNTW-1:0] bubble_cnt;

    int errors = 0;
    int checks = 0;

    e_stage_reg #(
        .DW(DW), .OPW(OPW), .RW(RW),
        .BUBBLE_OP(6'h3F), .LW_OP(6'h23), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_op(d_op), .d_pc(d_pc), .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .E_op(E_op), .E_pc(E_pc), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_valid(E_valid),
        .ld_use_hazard(ld_use_hazard), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] va,
                         input logic [31:0] vc, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] de, input logic [4:0] dm);
        d_op = op; d_pc = pc; d_valA = va; d_valB = 32'h7; d_valC = vc;
        d_srcA = sa; d_srcB = sb; d_dstE = de; d_dstM = dm;
    endtask

    initial begin
        rst_n = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
        set_d(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        #12 rst_n = 1'b1;

        // Reset values
        chk("rst_op",    32'(E_op), 32'h3F);
        chk("rst_valid", 32'(E_valid), 32'h0);
        chk("rst_cnt",   32'(bubble_cnt), 32'h0);
        chk("rst_pc",    E_pc, 32'h0);

        // One external bubble so the counter is non-zero
        E_bubble = 1'b1;
        tick();
        E_bubble = 1'b0;
        chk("ext_bub_cnt", 32'(bubble_cnt), 32'h1);

        // Pass-through
        set_d(6'h08, 32'h100, 32'h5, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd9, 5'd0);
        #1 chk("pt_hazard_pre", 32'(ld_use_hazard), 32'h0);
        tick();
        chk("pt_op",    32'(E_op), 32'h08);
        chk("pt_pc",    E_pc, 32'h100);
        chk("pt_valA",  E_valA, 32'h5);
        chk("pt_valB",  E_valB, 32'h7);
        chk("pt_valC",  E_valC, 32'hFFFF_FFFC);
        chk("pt_dstE",  32'(E_dstE), 32'h9);
        chk("pt_valid", 32'(E_valid), 32'h1);
        chk("pt_hazard", 32'(ld_use_hazard), 32'h0);
        chk("pt_cnt",   32'(bubble_cnt), 32'h1);

        // Asynchronous reset mid-cycle takes effect at once
        #3 rst_n = 1'b0;
        #1;
        chk("arst_op",    32'(E_op), 32'h3F);
        chk("arst_valid", 32'(E_valid), 32'h0);
        chk("arst_cnt",   32'(bubble_cnt), 32'h0);
        chk("arst_valA",  E_valA, 32'h0);
        rst_n = 1'b1;

        // Load-use via srcB
        set_d(6'h23, 32'h200, 32'h0, 32'h0, 5'd3, 5'd4, 5'd0, 5'd8);
        tick();
        chk("lw_op",   32'(E_op), 32'h23);
        chk("lw_dstM", 32'(E_dstM), 32'h8);
        set_d(6'h00, 32'h204, 32'h0, 32'h0, 5'd1, 5'd8, 5'd10, 5'd0);
        #1 chk("lu_hazard", 32'(ld_use_hazard), 32'h1);
        tick();
        chk("lu_valid", 32'(E_valid), 32'h0);
        chk("lu_op",    32'(E_op), 32'h3F);
        chk("lu_pc",    E_pc, 32'h0);
        chk("lu_cnt",   32'(bubble_cnt), 32'h1);
        chk("lu_hazard_clr", 32'(ld_use_hazard), 32'h0);
        tick();
        chk("lu_load_pc",    E_pc, 32'h204);
        chk("lu_load_op",    32'(E_op), 32'h00);
        chk("lu_load_valid", 32'(E_valid), 32'h1);
        chk("lu_load_dstE",  32'(E_dstE), 32'hA);

        // $0 guard
        set_d(6'h23, 32'h300, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        set_d(6'h08, 32'h304, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 5'd0);
        #1 chk("r0_hazard", 32'(ld_use_hazard), 32'h0);
        tick();
        chk("r0_pc",    E_pc, 32'h304);
        chk("r0_valid", 32'(E_valid), 32'h1);
        chk("r0_cnt",   32'(bubble_cnt), 32'h1);

        // Load-use via srcA
        set_d(6'h23, 32'h400, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd6);
        tick();
        set_d(6'h08, 32'h404, 32'h55, 32'h0, 5'd6, 5'd0, 5'd0, 5'd0);
        #1 chk("luA_hazard", 32'(ld_use_hazard), 32'h1);
        tick();
        chk("luA_valid", 32'(E_valid), 32'h0);
        chk("luA_cnt",   32'(bubble_cnt), 32'h2);
        tick();
        chk("luA_pc",   E_pc, 32'h404);
        chk("luA_valA", E_valA, 32'h55);

        // Stall holds for three edges, then stall+bubble flushes
        E_stall = 1'b1;
        set_d(6'h11, 32'h500, 32'h99, 32'h0, 5'd0, 5'd0, 5'd3, 5'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("st_pc",    E_pc, 32'h404);
        chk("st_op",    32'(E_op), 32'h08);
        chk("st_valA",  E_valA, 32'h55);
        chk("st_valid", 32'(E_valid), 32'h1);
        chk("st_cnt",   32'(bubble_cnt), 32'h2);
        E_bubble = 1'b1;
        tick();
        chk("sb_valid", 32'(E_valid), 32'h0);
        chk("sb_op",    32'(E_op), 32'h3F);
        chk("sb_cnt",   32'(bubble_cnt), 32'h3);
        E_bubble = 1'b0;
        E_stall  = 1'b0;
        tick();
        chk("sb_after_pc", E_pc, 32'h500);
        chk("sb_after_op", 32'(E_op), 32'h11);

        // Saturation at 15 with a 4-bit counter
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("sat_rst_cnt", 32'(bubble_cnt), 32'h0);
        E_bubble = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_cnt10", 32'(bubble_cnt), 32'hA);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt15", 32'(bubble_cnt), 32'hF);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt20", 32'(bubble_cnt), 32'hF);
        chk("sat_valid", 32'(E_valid), 32'h0);
        E_bubble = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
